// File: rtl/rr_reg_arbiter_pkg.sv
// rtl/rr_reg_arbiter_pkg.sv - shared types and rotate-from-pointer pick function for rr_reg_arbiter
package rr_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, BURST} arb_state_e;

    localparam int PICK_MAX = 32;
    localparam int PICK_IW  = $clog2(PICK_MAX);

    typedef struct packed {
        logic               found;
        logic [PICK_IW-1:0] idx;
    } pick_t;

    // First set bit of req[0 +: n] scanning upward from ptr, wrapping at n.
    function automatic pick_t rr_pick(input logic [PICK_MAX-1:0] req, input int ptr, input int n);
        pick_t r;
        int    k;
        r = '0;
        for (int i = PICK_MAX - 1; i >= 0; i--) begin
            k = ptr + i;
            if (k >= n) k = k - n;
            if (i < n && k >= 0 && k < PICK_MAX && req[k[PICK_IW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = k[PICK_IW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// rtl/rr_reg_arbiter_if.sv - requester/grant/output bundle between producers and rr_reg_arbiter
interface rr_reg_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ*WIDTH-1:0] data;
    logic [N_REQ-1:0]       gnt;
    logic [OW-1:0]          owner;
    logic [WIDTH-1:0]       O;
    logic                   O_valid;

    modport master (output req, lock, data, input gnt, owner, O, O_valid);
    modport slave  (input req, lock, data, output gnt, owner, O, O_valid);
endinterface

// File: rtl/rr_reg_arbiter_pick_enc.sv
// rtl/rr_reg_arbiter_pick_enc.sv - combinational rotate-from-ptr priority encoder
module rr_pick_enc
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             found,
    output logic [PW-1:0]    idx
);
    pick_t p;

    always_comb begin
        p     = rr_pick(PICK_MAX'(req), int'(ptr), N_REQ);
        // range guard keeps the unused upper index bits from being silently dropped
        found = p.found && (int'(p.idx) < N_REQ);
        idx   = p.idx[PW-1:0];
    end
endmodule

// File: rtl/rr_reg_arbiter.sv
// rtl/rr_reg_arbiter.sv - round-robin arbiter owning a shared output register; INLINE_ASSERT_EN embeds SVA checks
module rr_reg_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input logic            CLK,
    input logic            RESET,
    rr_reg_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e       state, state_nxt;
    logic [N_REQ-1:0] gnt_q, gnt_nxt, own_oh, pick_req;
    logic [PW-1:0]    owner_q, owner_nxt, ptr_q, ptr_nxt, rel_ptr, pick_ptr, pick_idx;
    logic [BW-1:0]    burst_q, burst_nxt;
    logic [WIDTH-1:0] o_q, o_nxt;
    logic             ov_q, ov_nxt, pick_found, release_w;
    logic [WIDTH-1:0] data_a [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_data
        assign data_a[i] = bus.data[i*WIDTH +: WIDTH];
    end

    always_comb begin
        own_oh          = '0;
        own_oh[owner_q] = 1'b1;
    end

    // Re-pick on release starts after the released owner and excludes it.
    assign rel_ptr  = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign pick_ptr = (state == IDLE) ? ptr_q : rel_ptr;
    assign pick_req = (state == IDLE) ? bus.req : (bus.req & ~own_oh);

    rr_pick_enc #(.N_REQ(N_REQ)) u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        owner_nxt = owner_q;
        ptr_nxt   = ptr_q;
        burst_nxt = burst_q;
        o_nxt     = o_q;
        ov_nxt    = 1'b0;
        release_w = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_nxt           = '0;
                    gnt_nxt[pick_idx] = 1'b1;
                    owner_nxt         = pick_idx;
                    state_nxt         = GRANT;
                end
            end
            GRANT, BURST: begin
                if (bus.req[owner_q]) begin
                    o_nxt  = data_a[owner_q];
                    ov_nxt = 1'b1;
                    if (bus.lock[owner_q] && (burst_q < BW'(MAX_BURST - 1))) begin
                        burst_nxt = burst_q + 1'b1;
                        state_nxt = BURST;
                    end else begin
                        release_w = 1'b1;
                    end
                end else begin
                    release_w = 1'b1;
                end
                if (release_w) begin
                    ptr_nxt   = rel_ptr;
                    burst_nxt = '0;
                    gnt_nxt   = '0;
                    if (pick_found) begin
                        gnt_nxt[pick_idx] = 1'b1;
                        owner_nxt         = pick_idx;
                        state_nxt         = GRANT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            o_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt_q   <= gnt_nxt;
            owner_q <= owner_nxt;
            ptr_q   <= ptr_nxt;
            burst_q <= burst_nxt;
            o_q     <= o_nxt;
            ov_q    <= ov_nxt;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.O       = o_q;
    assign bus.O_valid = ov_q;

`ifdef INLINE_ASSERT_EN
    localparam int MAX_WAIT = (N_REQ - 1) * MAX_BURST + 1;

    a_onehot: assert property (@(posedge CLK) disable iff (RESET) $onehot0(bus.gnt));
    a_xfer:   assert property (@(posedge CLK) disable iff (RESET) (|(bus.req & bus.gnt)) |-> ##1 bus.O_valid);
    a_valid:  assert property (@(posedge CLK) disable iff (RESET) bus.O_valid |-> $past(|(bus.req & bus.gnt)));
    a_burst:  assert property (@(posedge CLK) disable iff (RESET) int'(burst_q) < MAX_BURST);

    for (genvar i = 0; i < N_REQ; i++) begin : g_live
        a_live: assert property (@(posedge CLK) disable iff (RESET)
            (bus.req[i] && !bus.gnt[i]) |-> ##[1:MAX_WAIT] (bus.gnt[i] || !bus.req[i]));
    end
`endif
endmodule
